// File: rtl/ray_hit_collector_if.sv
// ray_hit_collector_if
//   Issue and result streams of the ray hit collector bundled into one
//   interface.
//   issue_valid/issue_ready/issue_id : launch handshake from the issue side.
//   res_valid/res_ready/res_id/res_hit : result stream to the consumer.
//   master : the issuing/consuming side. slave : the collector.
interface ray_hit_collector_if #(
  parameter int ID_W = 8
);
  logic            issue_valid;
  logic            issue_ready;
  logic [ID_W-1:0] issue_id;
  logic            res_valid;
  logic            res_ready;
  logic [ID_W-1:0] res_id;
  logic            res_hit;

  modport master (
    output issue_valid, issue_id, res_ready,
    input  issue_ready, res_valid, res_id, res_hit
  );

  modport slave (
    input  issue_valid, issue_id, res_ready,
    output issue_ready, res_valid, res_id, res_hit
  );
endinterface

// File: rtl/ray_hit_collector.sv
// ray_hit_collector
//   Downstream end of the ray/AABB intersection pipeline. Ray tags accepted on
//   the issue stream are delayed LAT cycles to line up with the core's
//   hit_miss bit, then the (id, hit) pair is queued in a DEPTH-entry FIFO and
//   offered on the result stream. Issue is credit-gated on FIFO occupancy plus
//   rays in flight, so the non-stallable core can never overflow the FIFO.
// Ports:
//   clk, rst            : rising-edge clock, async active-high reset
//   bus (slave)         : issue_valid/ready/id and res_valid/ready/id/hit
//   hit_miss            : core result bit, only meaningful in occupied slots
//   clr_stats           : synchronous clear of hit_cnt/miss_cnt
//   hit_cnt, miss_cnt   : saturating counts of hits/misses written to the FIFO
//   err_drop            : sticky, a launch was attempted while not ready
module ray_hit_collector #(
  parameter int LAT   = 8,
  parameter int ID_W  = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  ray_hit_collector_if.slave bus,
  input  logic             hit_miss,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             err_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LAT + 1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  // Tag delay line: valid bits are reset, tag bits are plain data.
  logic [LAT-1:0]  dl_v;
  logic [ID_W-1:0] dl_id [LAT];
  logic [IW-1:0]   inflight;

  // Result FIFO, each entry is {hit, id}.
  logic [ID_W:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            accept;
  logic            push;
  logic            pop;
  logic [ID_W-1:0] push_id;

  // Credit uses only registered occupancy, so a pop frees credit one cycle
  // later and the sum can never exceed DEPTH.
  assign bus.issue_ready = !rst && ((SW'(count) + SW'(inflight)) < SW'(DEPTH));

  assign accept  = bus.issue_valid && bus.issue_ready;
  assign push    = dl_v[LAT-1];
  assign push_id = dl_id[LAT-1];
  assign pop     = bus.res_valid && bus.res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_v     <= '0;
      inflight <= '0;
    end else begin
      dl_v[0] <= accept;
      for (int unsigned i = 1; i < LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
      end
      inflight <= inflight + IW'(accept) - IW'(push);
    end
  end

  always_ff @(posedge clk) begin
    dl_id[0] <= bus.issue_id;
    for (int unsigned i = 1; i < LAT; i++) begin
      dl_id[i] <= dl_id[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {hit_miss, push_id};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign bus.res_valid = (count != '0);
  // Head is forced to zero when empty so the stream reads 0 out of reset.
  assign {bus.res_hit, bus.res_id} = bus.res_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (clr_stats) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (push) begin
      if (hit_miss) begin
        if (hit_cnt != '1) begin
          hit_cnt <= hit_cnt + CNT_W'(1);
        end
      end else begin
        if (miss_cnt != '1) begin
          miss_cnt <= miss_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_drop <= 1'b0;
    end else if (bus.issue_valid && !bus.issue_ready) begin
      err_drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ray_hit_collector.sv
// tb_ray_hit_collector
//   Bench for ray_hit_collector. A queue-based reference model tracks rays in
//   flight (with their due cycle) and queued results; a negedge process
//   compares every DUT output against it each cycle. Directed phases add
//   hand-computed literal expectations.
module tb_ray_hit_collector;
  localparam int LAT   = 8;
  localparam int ID_W  = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             hit_miss;
  logic             clr_stats = 1'b0;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic             err_drop;

  ray_hit_collector_if #(.ID_W(ID_W)) bus ();

  ray_hit_collector #(
    .LAT(LAT), .ID_W(ID_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_miss(hit_miss),
    .clr_stats(clr_stats), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  // Core model: the hit bit chosen at issue time emerges LAT cycles later.
  logic           core_in = 1'b0;
  logic [LAT-1:0] core_sr = '0;
  always @(posedge clk) core_sr <= {core_sr[LAT-2:0], core_in};
  assign hit_miss = core_sr[LAT-1];

  typedef struct { logic [ID_W-1:0] id; int due; } pend_t;
  typedef struct { logic [ID_W-1:0] id; logic hit; } res_t;

  pend_t pend[$];
  res_t  fq[$];
  int    m_hit = 0;
  int    m_miss = 0;
  bit    m_err = 0;
  int    cyc = 0;
  int    acc0 = -1;
  int    res0 = -1;
  bit    m_rdy;
  bit    m_acc;
  bit    m_push;
  res_t  m_r;

  int    errors = 0;
  int    checks = 0;
  res_t  got[$];
  res_t  exp_q[$];

  function automatic bit m_ready();
    return !rst && ((fq.size() + pend.size()) < DEPTH);
  endfunction

  // Reference model: credit, in-flight rays keyed by due cycle, FIFO queue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
      fq.delete();
      m_hit = 0;
      m_miss = 0;
      m_err = 0;
    end else begin
      m_rdy = m_ready();
      m_acc = bus.issue_valid && m_rdy;
      if (bus.issue_valid && !m_rdy) m_err = 1;
      if (fq.size() > 0 && bus.res_ready) void'(fq.pop_front());
      m_push = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_r.id  = pend[0].id;
        m_r.hit = hit_miss;
        void'(pend.pop_front());
        fq.push_back(m_r);
        m_push = 1;
      end
      if (clr_stats) begin
        m_hit = 0;
        m_miss = 0;
      end else if (m_push) begin
        if (m_r.hit) m_hit = (m_hit < CMAX) ? m_hit + 1 : CMAX;
        else         m_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
      end
      if (m_acc) begin
        pend.push_back('{bus.issue_id, cyc + LAT});
        if (acc0 < 0) acc0 = cyc;
      end
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("issue_ready", 64'(bus.issue_ready), 64'(m_ready()));
    chk("res_valid", 64'(bus.res_valid), 64'(fq.size() > 0));
    if (fq.size() > 0) begin
      chk("res_id", 64'(bus.res_id), 64'(fq[0].id));
      chk("res_hit", 64'(bus.res_hit), 64'(fq[0].hit));
    end else begin
      chk("res_id_idle", 64'(bus.res_id), 64'd0);
      chk("res_hit_idle", 64'(bus.res_hit), 64'd0);
    end
    if (bus.res_valid) begin
      if (res0 < 0) res0 = cyc;
      if (bus.res_ready) got.push_back('{bus.res_id, bus.res_hit});
    end
    chk("hit_cnt", 64'(hit_cnt), 64'(m_hit));
    chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
    chk("err_drop", 64'(err_drop), 64'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  bit stream_hit[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int nacc;
  bit tog;

  initial begin
    bus.issue_valid = 1'b1;
    bus.issue_id    = '0;
    bus.res_ready   = 1'b0;

    // Reset held two edges with a launch attempted.
    tick();
    tick();
    chk("rst_ready", 64'(bus.issue_ready), 64'd0);
    chk("rst_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_hitcnt", 64'(hit_cnt), 64'd0);
    chk("rst_err", 64'(err_drop), 64'd0);
    rst = 1'b0;
    bus.issue_valid = 1'b0;
    bus.res_ready = 1'b1;
    #1;
    chk("post_rst_ready", 64'(bus.issue_ready), 64'd1);
    idle(LAT + 4);
    chk("post_rst_empty", 64'(got.size()), 64'd0);

    // Directed stream of six rays.
    got.delete();
    res0 = -1;
    for (int i = 0; i < 6; i++) begin
      bus.issue_valid = 1'b1;
      bus.issue_id = ID_W'(i);
      core_in = stream_hit[i];
      tick();
    end
    bus.issue_valid = 1'b0;
    core_in = 1'b0;
    idle(LAT + 6);
    chk("first_latency", 64'(res0 - 1 - acc0), 64'(LAT));
    chk("stream_count", 64'(got.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) begin
        chk("stream_id", 64'(got[i].id), 64'(i));
        chk("stream_hit", 64'(got[i].hit), 64'(stream_hit[i]));
      end
    end
    chk("stream_hitcnt", 64'(hit_cnt), 64'd4);
    chk("stream_misscnt", 64'(miss_cnt), 64'd2);

    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;

    // Backpressure: consumer stalled, driver honours ready.
    got.delete();
    bus.res_ready = 1'b0;
    nacc = 0;
    for (int c = 0; c < 40; c++) begin
      bus.issue_valid = bus.issue_ready;
      bus.issue_id = ID_W'(nacc);
      core_in = nacc[0];
      tick();
      if (bus.issue_valid) nacc++;
    end
    bus.issue_valid = 1'b0;
    chk("bp_accepted", 64'(nacc), 64'd16);
    chk("bp_ready_low", 64'(bus.issue_ready), 64'd0);
    chk("bp_err", 64'(err_drop), 64'd0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_pop_cycle", 64'(bus.issue_ready), 64'd0);
    @(negedge clk);
    chk("bp_ready_after_pop", 64'(bus.issue_ready), 64'd1);
    idle(20);
    chk("bp_drained", 64'(got.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < got.size()) begin
        chk("bp_id", 64'(got[i].id), 64'(i));
        chk("bp_hit", 64'(got[i].hit), 64'(i % 2));
      end
    end

    // Bubbles: issue every other cycle, core bit toggles every cycle.
    got.delete();
    exp_q.delete();
    tog = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tog = ~tog;
      core_in = tog;
      bus.issue_valid = (j % 2 == 0);
      bus.issue_id = ID_W'(8'h40 + j);
      if (j % 2 == 0) exp_q.push_back('{ID_W'(8'h40 + j), 1'b1});
      tick();
    end
    bus.issue_valid = 1'b0;
    idle(LAT + 4);
    chk("bubble_count", 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) begin
        chk("bubble_id", 64'(got[i].id), 64'(exp_q[i].id));
        chk("bubble_hit", 64'(got[i].hit), 64'(exp_q[i].hit));
      end
    end

    // Mid-operation reset: 3 results queued, 5 rays in flight.
    bus.res_ready = 1'b0;
    core_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.issue_valid = 1'b1;
      bus.issue_id = ID_W'(8'h80 + i);
      tick();
    end
    bus.issue_valid = 1'b0;
    idle(3);
    chk("mid_pre_valid", 64'(bus.res_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_async_valid", 64'(bus.res_valid), 64'd0);
    chk("mid_async_ready", 64'(bus.issue_ready), 64'd0);
    tick();
    rst = 1'b0;
    bus.res_ready = 1'b1;
    for (int n = 0; n < LAT + 4; n++) begin
      tick();
      chk("mid_quiet", 64'(bus.res_valid), 64'd0);
    end

    // Saturation of a 4-bit hit counter.
    nacc = 0;
    for (int c = 0; c < 60 && nacc < 20; c++) begin
      bus.issue_valid = bus.issue_ready;
      bus.issue_id = ID_W'(nacc);
      tick();
      if (bus.issue_valid) nacc++;
    end
    bus.issue_valid = 1'b0;
    idle(LAT + 4);
    chk("sat_accepted", 64'(nacc), 64'd20);
    chk("sat_hitcnt", 64'(hit_cnt), 64'd15);
    chk("sat_misscnt", 64'(miss_cnt), 64'd0);

    // Clear coinciding with a hit push.
    bus.issue_valid = 1'b1;
    bus.issue_id = 8'hAA;
    tick();
    bus.issue_valid = 1'b0;
    idle(LAT - 1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_push_seen", 64'(bus.res_valid), 64'd1);
    chk("clr_priority", 64'(hit_cnt), 64'd0);
    idle(2);

    // Illegal launch while not ready sets the sticky flag.
    bus.res_ready = 1'b0;
    core_in = 1'b0;
    for (int c = 0; c < 30; c++) begin
      bus.issue_valid = bus.issue_ready;
      tick();
    end
    bus.issue_valid = 1'b1;
    tick();
    bus.issue_valid = 1'b0;
    chk("err_set", 64'(err_drop), 64'd1);
    bus.res_ready = 1'b1;
    idle(LAT + 20);
    chk("err_sticky", 64'(err_drop), 64'd1);
    rst = 1'b1;
    #2;
    chk("err_cleared", 64'(err_drop), 64'd0);
    tick();
    rst = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ray_hit_collector.md
Name: ray_hit_collector

Overview:
- Downstream end of the Ray_AABB_11_23 intersection pipeline.
- The issue side supplies a ray tag each time a ray's 37-bit interval operands are launched into the fixed-latency core. This block delays those tags by the core latency and pairs each tag with the core's hit_miss bit.
- Each (id, hit) pair is buffered in a FIFO and presented on a valid/ready result stream.
- Issue is credit-gated so that a result is never dropped; the core itself cannot stall.

Parameters:
- LAT, 8, core pipeline latency in cycles (issue sampling edge to hit_miss sampling edge); legal range ≥1.
- ID_W, 8, ray tag width.
- DEPTH, 16, result FIFO entries; power of two, ≥2.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- issue_valid  in  1  a ray is being launched into the core this cycle.
- issue_ready  out  1  the collector can accept a launch.
- issue_id  in  ID_W  tag of the launched ray.
- hit_miss  in  1  core result bit; meaningful only in LAT-aligned slots.
- res_valid  out  1  FIFO head is valid.
- res_ready  in  1  consumer accepts the head.
- res_id  out  ID_W  tag at the FIFO head.
- res_hit  out  1  hit bit at the FIFO head (1 = hit).
- clr_stats  in  1  synchronous clear of the statistics counters.
- hit_cnt  out  CNT_W  saturating count of hits written to the FIFO.
- miss_cnt  out  CNT_W  saturating count of misses written to the FIFO.
- err_drop  out  1  sticky flag: issue_valid was asserted while issue_ready=0.

Behaviour:
- Reset (async assert, sync release):
  - Delay line valids cleared; FIFO emptied; counters zero.
  - res_valid=0, res_id=0, res_hit=0, hit_cnt=0, miss_cnt=0, err_drop=0.
  - issue_ready=0 while rst is high.
  - In-flight tags are discarded. Core results that arrive after reset release are ignored, because their slot valids are 0.
- Launch: accepted at edge k when issue_valid & issue_ready; {1, issue_id} enters stage 0 of the LAT-deep delay line. Otherwise {0, x} enters stage 0. The delay line shifts every cycle unconditionally.
- Capture: at edge k+LAT, if the delay-line output valid is 1, {id, hit_miss} is pushed into the FIFO. If the output valid is 0, hit_miss is ignored.
- Minimum latency: res_valid rises in the cycle after edge k+LAT when the FIFO was empty, i.e. LAT cycles after the accepting edge.
- Credit:
  - issue_ready = rst==0 & (fifo_count + inflight) < DEPTH.
  - inflight is the number of valid delay-line stages, held as a registered up/down counter.
  - A pop frees credit from the next cycle, not combinationally.
  - Consequence: a FIFO push is never attempted when the FIFO is full.
- Result stream:
  - A pop occurs on res_valid & res_ready.
  - res_id and res_hit are held stable while res_valid & !res_ready.
  - Order is strictly issue order.
  - Simultaneous push and pop is legal in any state, including empty (the push is visible the next cycle) and full-1; fifo_count is unchanged in that case.
  - Pointers wrap modulo DEPTH.
- Statistics:
  - On each push, hit_cnt or miss_cnt increments, saturating at 2^CNT_W-1.
  - clr_stats has priority over a same-cycle increment: the result is 0.
- err_drop: set when issue_valid & !issue_ready with rst=0; cleared only by rst. The attempted launch is not recorded. The upstream must not launch the core when issue_ready=0.

Test Plan:
- Reset: hold rst 2 cycles with issue_valid=1 -> res_valid=0, issue_ready=0, counts 0, err_drop=0. After release: issue_ready=1, no results ever appear.
- Stream:
  - Stimulus: issue ids 0..5 on consecutive edges alongside the six Ray_AABB_11_23 directed vectors (hit1, hit2, miss, hit2, hit1 with x=1, hit3), res_ready=1.
  - Results: (0,1),(1,1),(2,0),(3,1),(4,0),(5,1) on consecutive cycles, the first exactly LAT cycles after the id-0 accepting edge.
  - Final counts: hit_cnt=4, miss_cnt=2.
- Backpressure:
  - Stimulus: res_ready=0, issue_valid=1 continuously.
  - Response: exactly 16 launches accepted, then issue_ready=0; err_drop stays 0 when the driver honours ready.
  - Release: res_ready=1 -> ids 0..15 drain in order, issue_ready returns one cycle after the first pop.
- Bubbles: issue on alternate cycles while the core model toggles hit_miss every cycle -> only the issued ids are output, with the hit bits from their own slots; no spurious entries.
- Mid-operation reset: 5 rays in flight plus 3 results in the FIFO, 1-cycle rst pulse -> res_valid=0 immediately (async). No results appear for the next LAT+4 cycles, even though the core model continues to drive hit_miss=1.
- Saturation/clear:
  - CNT_W=4 instance, 20 hits -> hit_cnt=15.
  - clr_stats pulsed in the same cycle as a hit push -> hit_cnt=0 the next cycle.
  - Launching with issue_ready=0 -> err_drop=1, held until rst.
